// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: shared FSM encoding and timing constants for mac_sequencer.
package mac_seq_pkg;

    // Operand-buffer read latency in cycles (rd_en -> data at PE row)
    localparam int RD_LAT = 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mac_sequencer.sv
// mac_sequencer: drives one dot-product pass through a chained PE row.
// Sequence: CLEAR accumulators, FEED vec_len operands, DRAIN the pipeline, pulse done.
// Optional busy-cycle counter enabled by defining MAC_SEQ_PERF_CNT_EN.
module mac_sequencer
    import mac_seq_pkg::*;
#(
    parameter int NUM_PE = 4,
    parameter int LEN_W  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              pe_clear,
    output logic              pe_en,
    output logic              busy,
    output logic              done,
    output logic [31:0]       perf_cycles
);

    // Drain covers the buffer read latency plus the skew across the PE chain
    localparam int DRAIN_CYC = RD_LAT + NUM_PE - 1;
    localparam int DRN_W     = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    generate
        if (LEN_W > ADDR_W) begin : g_bad_width
            $error("mac_sequencer: LEN_W must not exceed ADDR_W");
        end
    endgenerate

    state_t             state;
    logic [LEN_W-1:0]   len_q;
    logic [DRN_W-1:0]   drn_cnt;
    logic [ADDR_W-1:0]  last_addr;

    // Address of the final operand; len_q is zero-extended so upper address bits stay 0
    assign last_addr = ADDR_W'(len_q) - ADDR_W'(1);

    // Pass sequencing FSM; every output is a register updated on the transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            len_q    <= '0;
            drn_cnt  <= '0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            pe_clear <= 1'b0;
            pe_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // PE enable trails the read strobe by the buffer latency
            pe_en    <= rd_en;
            pe_clear <= 1'b0;
            done     <= 1'b0;
            if (abort && state != S_IDLE) begin
                state <= S_IDLE;
                rd_en <= 1'b0;
                pe_en <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            len_q    <= vec_len;
                            state    <= S_CLEAR;
                            pe_clear <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                    S_CLEAR: begin
                        if (len_q != '0) begin
                            state   <= S_FEED;
                            rd_en   <= 1'b1;
                            rd_addr <= '0;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                    S_FEED: begin
                        if (rd_addr == last_addr) begin
                            state   <= S_DRAIN;
                            rd_en   <= 1'b0;
                            drn_cnt <= '0;
                        end else begin
                            rd_addr <= rd_addr + ADDR_W'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (drn_cnt == DRN_W'(DRAIN_CYC - 1)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            drn_cnt <= drn_cnt + DRN_W'(1);
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        rd_en <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef MAC_SEQ_PERF_CNT_EN
    // Saturating busy-cycle counter, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst)
            perf_cycles <= '0;
        else if (busy && perf_cycles != 32'hFFFF_FFFF)
            perf_cycles <= perf_cycles + 32'd1;
    end
`else
    assign perf_cycles = '0;
`endif

endmodule
